// File: rtl/reg_wb_arbiter_if.sv
// Write-back bus bundle: flattened per-source request lanes in, one register-file write port out.
// Source i occupies [i*WIDTH +: WIDTH] of src_data and [i*AW +: AW] of src_addr; src_ready is combinational.
interface reg_wb_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 5,
  parameter int AW    = 3,
  parameter int SW    = (NSRC > 1) ? $clog2(NSRC) : 1
);
  logic [NSRC-1:0]       src_valid;
  logic [NSRC-1:0]       src_ready;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC*AW-1:0]    src_addr;
  logic                  wr_stall;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [SW-1:0]         wr_src;
  logic                  busy;

  modport slave (
    input  src_valid, src_data, src_addr, wr_stall,
    output src_ready, wr_en, wr_addr, wr_data, wr_src, busy
  );

  modport master (
    output src_valid, src_data, src_addr, wr_stall,
    input  src_ready, wr_en, wr_addr, wr_data, wr_src, busy
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register write-back arbiter: one holding slot per source, fixed-priority or round-robin pick; 2-cycle accept-to-write.
// Backpressure: wr_stall freezes grants and outputs; a source is ready when its slot is empty or being drained.
module reg_wb_arbiter #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 5,
  parameter int AW    = 3,
  parameter int RR    = 0,
  parameter int SW    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic           clk,
  input  logic           rst_b,
  reg_wb_arbiter_if.slave bus
);

  logic [NSRC-1:0]  slot_v;
  logic [AW-1:0]    slot_addr [NSRC];
  logic [WIDTH-1:0] slot_data [NSRC];

  logic [NSRC-1:0]  grant;
  logic [NSRC-1:0]  ready;
  logic [NSRC-1:0]  accept;
  logic             gnt_any;
  logic [SW-1:0]    gnt_idx;
  logic [SW-1:0]    rr_ptr;

  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic [SW-1:0]    wr_src_q;

  // Only parked slots compete; the search starts at rr_ptr in round-robin mode, at 0 otherwise.
  always_comb begin
    int k;
    k       = 0;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!bus.wr_stall) begin
      for (int n = 0; n < NSRC; n++) begin
        k = n;
        if (RR != 0) begin
          k = int'(rr_ptr) + n;
          if (k >= NSRC) k = k - NSRC;
        end
        if (!gnt_any && slot_v[k]) begin
          gnt_any  = 1'b1;
          gnt_idx  = SW'(k);
          grant[k] = 1'b1;
        end
      end
    end
  end

  assign ready  = ~slot_v | grant;
  assign accept = bus.src_valid & ready;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      slot_v    <= '0;
      rr_ptr    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
    end else begin
      // A reload on the granting edge wins, so the slot stays occupied with the new request.
      for (int i = 0; i < NSRC; i++) begin
        if (accept[i]) begin
          slot_v[i]    <= 1'b1;
          slot_addr[i] <= bus.src_addr[i*AW +: AW];
          slot_data[i] <= bus.src_data[i*WIDTH +: WIDTH];
        end else if (grant[i]) begin
          slot_v[i] <= 1'b0;
        end
      end
      if (!bus.wr_stall) begin
        wr_en_q <= gnt_any;
        if (gnt_any) begin
          wr_addr_q <= slot_addr[gnt_idx];
          wr_data_q <= slot_data[gnt_idx];
          wr_src_q  <= gnt_idx;
          if (RR != 0) begin
            rr_ptr <= (gnt_idx == SW'(NSRC - 1)) ? '0 : gnt_idx + SW'(1);
          end
        end
      end
    end
  end

  assign bus.src_ready = ready;
  assign bus.busy      = |slot_v;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_src    = wr_src_q;

endmodule
